alu_wb_buffer: RTL and testbench
================================

Name: alu_wb_buffer

Overview:
- Result stage directly downstream of cv32e40p_alu.
- Captures `result_o` / `comparison_result_o` with a destination register address into a small in-order FIFO, and presents the entries to the register-file write port over a valid/ready handshake.
- Exposes a forwarding lookup so the operand-select stage can bypass pending results into `operand_a_i` / `operand_b_i` of the ALU.
- Keeps a running count of committed writes.

Parameters:
- DEPTH, 2, number of buffered results; power of two, 2..8.
- CNT_W, 32, width of the commit counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset. One clock; reset is synchronous and active-high.
- flush_i  input  1  discard all buffered entries (pipeline kill).
- alu_valid_i  input  1  ALU result valid this cycle.
- alu_ready_o  output  1  buffer can accept a result.
- alu_result_i  input  32  ALU `result_o`.
- alu_cmp_i  input  1  ALU `comparison_result_o`.
- alu_is_cmp_i  input  1  1 = write the comparison bit instead of the result.
- rd_addr_i  input  5  destination register.
- wb_valid_o  output  1  head entry valid.
- wb_ready_i  input  1  register file accepts the head entry.
- wb_addr_o  output  5  head destination register.
- wb_data_o  output  32  head write data.
- fwd_addr_i  input  5  register being read by the operand stage.
- fwd_hit_o  output  1  a pending entry targets fwd_addr_i.
- fwd_data_o  output  32  data of the youngest matching entry.
- occupancy_o  output  $clog2(DEPTH)+1  number of stored entries.
- commit_cnt_o  output  CNT_W  number of completed write-backs.

Behaviour:
- Reset (rst=1 at an edge):
  - count, read pointer and write pointer go to 0; commit_cnt_o=0.
  - Storage contents are don't-care.
  - While rst is high, alu_ready_o=0, wb_valid_o=0 and fwd_hit_o=0.
  - Reset takes priority over every other input.
- Accept: occurs when alu_valid_i && alu_ready_o.
  - alu_ready_o = (count != DEPTH) && !rst. It is derived from registered state only, with no combinational path from wb_ready_i.
- Data formation:
  - wb_data = alu_is_cmp_i ? {31'b0, alu_cmp_i} : alu_result_i.
- x0 writes: an accepted result with rd_addr_i == 0 completes the handshake but is not stored, not forwarded and not counted.
- Latency: an accepted entry appears on wb_valid_o / wb_addr_o / wb_data_o on the cycle after acceptance. There is no same-cycle bypass from the input to the output.
- Output side:
  - wb_valid_o = (count != 0).
  - wb_addr_o / wb_data_o come from the head entry and stay stable while wb_valid_o && !wb_ready_i.
  - They are 0 when the buffer is empty.
- Dequeue: occurs when wb_valid_o && wb_ready_i. The read pointer advances modulo DEPTH, and commit_cnt_o increments, wrapping from 2^CNT_W-1 to 0.
- Simultaneous accept and dequeue (count < DEPTH): count is unchanged and both pointers advance.
- Full: when count == DEPTH, alu_ready_o=0, so a dequeue in that cycle does not allow an accept in the same cycle.
- Pointer wrap: pointers wrap modulo DEPTH, and ordering stays strictly FIFO across the wrap.
- Flush:
  - Sets count and both pointers to 0 at the edge.
  - Overrides any accept or dequeue in the same cycle; a handshake that cycle is lost and not counted.
  - commit_cnt_o is not affected.
- Forwarding (combinational):
  - Compare fwd_addr_i against every stored entry, youngest first. The first match drives fwd_hit_o=1 and fwd_data_o.
  - If fwd_addr_i == 0 or there is no match, fwd_hit_o=0 and fwd_data_o=0.
  - The incoming, not-yet-stored result is not searched.
- occupancy_o = count (registered).

Test Plan:
- Reset then an ALU_AND result: result 0x1, rd=5, valid for 1 cycle with wb_ready_i=0.
  - Next cycle: wb_valid_o=1, wb_addr_o=5, wb_data_o=0x1, occupancy_o=1.
  - Raise wb_ready_i: entry drains and commit_cnt_o=1.
- Fill/full: push 0x7 (rd=1) and 0x6 (rd=2) with wb_ready_i=0.
  - alu_ready_o=0 and occupancy_o=2.
  - A third valid result is held by the ALU side and not accepted.
  - Drain gives rd1/0x7 then rd2/0x6 in order; commit_cnt_o=2.
- Comparison and x0:
  - Push alu_is_cmp_i=1, cmp=1, result=0xFFFFFFFF, rd=3: wb_data_o=0x00000001.
  - Push rd=0, 0x1234: accepted but occupancy_o is unchanged and no write appears.
- Forwarding: store rd=4/0xA, then rd=4/0xB, with fwd_addr_i=4.
  - fwd_hit_o=1 and fwd_data_o=0xB (youngest wins).
  - fwd_addr_i=0 gives fwd_hit_o=0.
- Flush collision: buffer holds 2 entries; assert flush_i together with alu_valid_i and wb_ready_i.
  - Next cycle: occupancy_o=0, wb_valid_o=0, and commit_cnt_o is unchanged.
- Continuous streaming with wrap: alu_valid_i=1 and wb_ready_i=1 for 10 cycles with data 0..9.
  - Outputs 0..9 in order, each 1 cycle after its accept.
  - occupancy_o stays 1 after the first cycle; commit_cnt_o ends at 9, with the 10th entry still pending.
- Reset mid-operation: assert rst with 2 entries stored; all outputs return to 0 on the next edge.

Source files
------------

// File: rtl/alu_wb_buffer.sv
// rtl/alu_wb_buffer.sv - in-order result FIFO between the ALU and the register-file write port
// Provides youngest-first operand forwarding and a running commit counter.
module alu_wb_buffer #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     alu_valid_i,
    output logic                     alu_ready_o,
    input  logic [31:0]              alu_result_i,
    input  logic                     alu_cmp_i,
    input  logic                     alu_is_cmp_i,
    input  logic [4:0]               rd_addr_i,
    output logic                     wb_valid_o,
    input  logic                     wb_ready_i,
    output logic [4:0]               wb_addr_o,
    output logic [31:0]              wb_data_o,
    input  logic [4:0]               fwd_addr_i,
    output logic                     fwd_hit_o,
    output logic [31:0]              fwd_data_o,
    output logic [$clog2(DEPTH):0]   occupancy_o,
    output logic [CNT_W-1:0]         commit_cnt_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [4:0]       r_addr [DEPTH];
    logic [31:0]      r_data [DEPTH];
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W-1:0] r_wptr;
    logic [OCC_W-1:0] r_count;
    logic [CNT_W-1:0] r_commit;

    logic        w_accept;
    logic        w_store;
    logic        w_deq;
    logic [31:0] w_in_data;

    assign alu_ready_o = (r_count != OCC_W'(DEPTH)) && !rst;
    assign wb_valid_o  = (r_count != '0) && !rst;
    assign wb_addr_o   = wb_valid_o ? r_addr[r_rptr] : 5'd0;
    assign wb_data_o   = wb_valid_o ? r_data[r_rptr] : 32'd0;

    assign w_accept  = alu_valid_i && alu_ready_o;
    // Writes to x0 finish the handshake but never occupy a slot.
    assign w_store   = w_accept && (rd_addr_i != 5'd0) && !flush_i;
    assign w_deq     = wb_valid_o && wb_ready_i && !flush_i;
    assign w_in_data = alu_is_cmp_i ? {31'b0, alu_cmp_i} : alu_result_i;

    always_ff @(posedge clk) begin
        if (w_store) begin
            r_addr[r_wptr] <= rd_addr_i;
            r_data[r_wptr] <= w_in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rptr   <= '0;
            r_wptr   <= '0;
            r_count  <= '0;
            r_commit <= '0;
        end else if (flush_i) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_store) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_deq) begin
                r_rptr   <= r_rptr + PTR_W'(1);
                r_commit <= r_commit + CNT_W'(1);
            end
            if (w_store && !w_deq) begin
                r_count <= r_count + OCC_W'(1);
            end else if (!w_store && w_deq) begin
                r_count <= r_count - OCC_W'(1);
            end
        end
    end

    // Walk oldest to youngest so the last match (youngest) wins.
    always_comb begin
        fwd_hit_o  = 1'b0;
        fwd_data_o = 32'd0;
        if (!rst && fwd_addr_i != 5'd0) begin
            for (int i = 0; i < DEPTH; i++) begin
                if ((OCC_W'(i) < r_count) && (r_addr[r_rptr + PTR_W'(i)] == fwd_addr_i)) begin
                    fwd_hit_o  = 1'b1;
                    fwd_data_o = r_data[r_rptr + PTR_W'(i)];
                end
            end
        end
    end

    assign occupancy_o  = r_count;
    assign commit_cnt_o = r_commit;

endmodule

// File: tb/tb_alu_wb_buffer.sv
// tb/tb_alu_wb_buffer.sv - directed table-driven bench for alu_wb_buffer
module tb_alu_wb_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        alu_valid_i;
    logic        alu_ready_o;
    logic [31:0] alu_result_i;
    logic        alu_cmp_i;
    logic        alu_is_cmp_i;
    logic [4:0]  rd_addr_i;
    logic        wb_valid_o;
    logic        wb_ready_i;
    logic [4:0]  wb_addr_o;
    logic [31:0] wb_data_o;
    logic [4:0]  fwd_addr_i;
    logic        fwd_hit_o;
    logic [31:0] fwd_data_o;
    logic [1:0]  occupancy_o;
    logic [31:0] commit_cnt_o;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_wb_buffer #(.DEPTH(2), .CNT_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush_i),
        .alu_valid_i  (alu_valid_i),
        .alu_ready_o  (alu_ready_o),
        .alu_result_i (alu_result_i),
        .alu_cmp_i    (alu_cmp_i),
        .alu_is_cmp_i (alu_is_cmp_i),
        .rd_addr_i    (rd_addr_i),
        .wb_valid_o   (wb_valid_o),
        .wb_ready_i   (wb_ready_i),
        .wb_addr_o    (wb_addr_o),
        .wb_data_o    (wb_data_o),
        .fwd_addr_i   (fwd_addr_i),
        .fwd_hit_o    (fwd_hit_o),
        .fwd_data_o   (fwd_data_o),
        .occupancy_o  (occupancy_o),
        .commit_cnt_o (commit_cnt_o)
    );

    typedef struct {
        logic        v;
        logic [31:0] res;
        logic        cmp;
        logic        isc;
        logic [4:0]  rd;
        logic        rdy;
        logic        fl;
        logic [4:0]  fa;
        logic        e_wv;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        logic [1:0]  e_occ;
        logic [31:0] e_cc;
        logic        e_ar;
        logic        e_hit;
        logic [31:0] e_fd;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] res, input logic cmp, input logic isc,
                         input logic [4:0] rd, input logic rdy, input logic fl, input logic [4:0] fa);
        alu_valid_i  = v;
        alu_result_i = res;
        alu_cmp_i    = cmp;
        alu_is_cmp_i = isc;
        rd_addr_i    = rd;
        wb_ready_i   = rdy;
        flush_i      = fl;
        fwd_addr_i   = fa;
    endtask

    initial begin
        //          v  res           cmp  isc  rd     rdy  fl   fa    | wv  wa     wd            occ  cc     ar   hit  fd
        vecs[0]  = '{1, 32'h1,        0,   0,  5'd5,  0,   0,  5'd0,   1, 5'd5,  32'h1,        2'd1, 32'd0, 1,   0,  32'h0};
        vecs[1]  = '{0, 32'h0,        0,   0,  5'd0,  1,   0,  5'd0,   0, 5'd0,  32'h0,        2'd0, 32'd1, 1,   0,  32'h0};
        vecs[2]  = '{1, 32'h7,        0,   0,  5'd1,  0,   0,  5'd0,   1, 5'd1,  32'h7,        2'd1, 32'd1, 1,   0,  32'h0};
        vecs[3]  = '{1, 32'h6,        0,   0,  5'd2,  0,   0,  5'd0,   1, 5'd1,  32'h7,        2'd2, 32'd1, 0,   0,  32'h0};
        vecs[4]  = '{1, 32'h9,        0,   0,  5'd7,  0,   0,  5'd2,   1, 5'd1,  32'h7,        2'd2, 32'd1, 0,   1,  32'h6};
        vecs[5]  = '{1, 32'h9,        0,   0,  5'd7,  1,   0,  5'd7,   1, 5'd2,  32'h6,        2'd1, 32'd2, 1,   0,  32'h0};
        vecs[6]  = '{0, 32'h0,        0,   0,  5'd0,  1,   0,  5'd0,   0, 5'd0,  32'h0,        2'd0, 32'd3, 1,   0,  32'h0};
        vecs[7]  = '{1, 32'hFFFFFFFF, 1,   1,  5'd3,  0,   0,  5'd3,   1, 5'd3,  32'h1,        2'd1, 32'd3, 1,   1,  32'h1};
        vecs[8]  = '{1, 32'h1234,     0,   0,  5'd0,  0,   0,  5'd0,   1, 5'd3,  32'h1,        2'd1, 32'd3, 1,   0,  32'h0};
        vecs[9]  = '{0, 32'h0,        0,   0,  5'd0,  1,   0,  5'd0,   0, 5'd0,  32'h0,        2'd0, 32'd4, 1,   0,  32'h0};
        vecs[10] = '{1, 32'hA,        0,   0,  5'd4,  0,   0,  5'd4,   1, 5'd4,  32'hA,        2'd1, 32'd4, 1,   1,  32'hA};
        vecs[11] = '{1, 32'hB,        0,   0,  5'd4,  0,   0,  5'd4,   1, 5'd4,  32'hA,        2'd2, 32'd4, 0,   1,  32'hB};
        vecs[12] = '{0, 32'h0,        0,   0,  5'd0,  0,   0,  5'd0,   1, 5'd4,  32'hA,        2'd2, 32'd4, 0,   0,  32'h0};
        vecs[13] = '{1, 32'hC,        0,   0,  5'd6,  1,   1,  5'd4,   0, 5'd0,  32'h0,        2'd0, 32'd4, 1,   0,  32'h0};

        rst = 1'b1;
        drive(1, 32'h5, 0, 0, 5'd9, 1, 0, 5'd9);
        tick();
        tick();
        check("rst_alu_ready", {31'b0, alu_ready_o}, 32'd0);
        check("rst_wb_valid",  {31'b0, wb_valid_o},  32'd0);
        check("rst_fwd_hit",   {31'b0, fwd_hit_o},   32'd0);
        check("rst_occ",       {30'b0, occupancy_o}, 32'd0);
        check("rst_commit",    commit_cnt_o,         32'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", {31'b0, alu_ready_o}, 32'd1);

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].v, vecs[i].res, vecs[i].cmp, vecs[i].isc, vecs[i].rd,
                  vecs[i].rdy, vecs[i].fl, vecs[i].fa);
            tick();
            check($sformatf("v%0d_wb_valid", i), {31'b0, wb_valid_o},   {31'b0, vecs[i].e_wv});
            check($sformatf("v%0d_wb_addr", i),  {27'b0, wb_addr_o},    {27'b0, vecs[i].e_wa});
            check($sformatf("v%0d_wb_data", i),  wb_data_o,             vecs[i].e_wd);
            check($sformatf("v%0d_occ", i),      {30'b0, occupancy_o},  {30'b0, vecs[i].e_occ});
            check($sformatf("v%0d_commit", i),   commit_cnt_o,          vecs[i].e_cc);
            check($sformatf("v%0d_alu_ready", i),{31'b0, alu_ready_o},  {31'b0, vecs[i].e_ar});
            check($sformatf("v%0d_fwd_hit", i),  {31'b0, fwd_hit_o},    {31'b0, vecs[i].e_hit});
            check($sformatf("v%0d_fwd_data", i), fwd_data_o,            vecs[i].e_fd);
        end

        // Streaming through the pointer wrap: each result shows up one cycle after acceptance.
        for (int k = 0; k < 10; k++) begin
            drive(1, 32'(k), 0, 0, 5'(k + 1), 1, 0, 0);
            tick();
            check($sformatf("s%0d_wb_valid", k), {31'b0, wb_valid_o},  32'd1);
            check($sformatf("s%0d_wb_data", k),  wb_data_o,            32'(k));
            check($sformatf("s%0d_wb_addr", k),  {27'b0, wb_addr_o},   32'(k + 1));
            check($sformatf("s%0d_occ", k),      {30'b0, occupancy_o}, 32'd1);
            check($sformatf("s%0d_commit", k),   commit_cnt_o,         32'(4 + k));
        end

        // Second entry stored behind the pending 10th, then reset mid-operation.
        drive(1, 32'h55, 0, 0, 5'd20, 0, 0, 5'd20);
        tick();
        check("pre_rst_occ",      {30'b0, occupancy_o}, 32'd2);
        check("pre_rst_fwd_hit",  {31'b0, fwd_hit_o},   32'd1);
        check("pre_rst_fwd_data", fwd_data_o,           32'h55);
        drive(0, 0, 0, 0, 0, 0, 0, 5'd20);
        rst = 1'b1;
        tick();
        check("mid_rst_wb_valid", {31'b0, wb_valid_o},  32'd0);
        check("mid_rst_wb_addr",  {27'b0, wb_addr_o},   32'd0);
        check("mid_rst_wb_data",  wb_data_o,            32'd0);
        check("mid_rst_occ",      {30'b0, occupancy_o}, 32'd0);
        check("mid_rst_commit",   commit_cnt_o,         32'd0);
        check("mid_rst_ready",    {31'b0, alu_ready_o}, 32'd0);
        check("mid_rst_fwd_hit",  {31'b0, fwd_hit_o},   32'd0);
        rst = 1'b0;
        tick();
        check("after_rst_ready",  {31'b0, alu_ready_o}, 32'd1);
        check("after_rst_fwd",    {31'b0, fwd_hit_o},   32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
